// File: rtl/countdown_timer.sv
// BCD mm:ss cook-time countdown. A rising edge on load captures the keypad preset,
// start/pause pulses run and halt the count, done pulses once when 00:00 is reached.
module countdown_timer #(
  parameter int unsigned CLK_PER_SEC = 50_000_000
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       zero,
  output logic       done
);

  localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PreLast = PW'(CLK_PER_SEC - 1);
  localparam logic [PW-1:0] PreOne  = PW'(1);

  typedef enum logic [1:0] {StIdle, StRunning, StPaused, StDone} state_e;

  state_e        state;
  logic [PW-1:0] prescaler;
  logic          load_q;
  logic          load_armed;
  logic          load_rise;
  logic [7:0]    cap_min, cap_sec;
  logic          cap_zero;
  logic [7:0]    dec_min, dec_sec;
  logic          dec_zero;

  function automatic logic [3:0] clamp_nibble(input logic [3:0] n, input logic [3:0] lim);
    return (n > lim) ? lim : n;
  endfunction

  // A level already high when reset releases must not count as a rising edge, so the
  // detector only arms once load has been seen low after reset.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      load_q     <= 1'b0;
      load_armed <= 1'b0;
    end else begin
      load_q <= load;
      if (!load) load_armed <= 1'b1;
    end
  end

  assign load_rise = load & ~load_q & load_armed;

  // Sanitised preset: nibbles above 9 become 9, seconds tens above 5 becomes 5.
  always_comb begin
    cap_min  = {clamp_nibble(preset_min[7:4], 4'd9), clamp_nibble(preset_min[3:0], 4'd9)};
    cap_sec  = {clamp_nibble(preset_sec[7:4], 4'd5), clamp_nibble(preset_sec[3:0], 4'd9)};
    cap_zero = (cap_min == 8'h00) && (cap_sec == 8'h00);
  end

  // One-second BCD decrement with borrow; never evaluated at 00:00 while counting.
  always_comb begin
    dec_min = min_bcd;
    dec_sec = sec_bcd;
    if (sec_bcd[3:0] != 4'd0) begin
      dec_sec[3:0] = sec_bcd[3:0] - 4'd1;
    end else if (sec_bcd[7:4] != 4'd0) begin
      dec_sec = {sec_bcd[7:4] - 4'd1, 4'd9};
    end else begin
      dec_sec = 8'h59;
      if (min_bcd[3:0] != 4'd0) dec_min[3:0] = min_bcd[3:0] - 4'd1;
      else                      dec_min      = {min_bcd[7:4] - 4'd1, 4'd9};
    end
    dec_zero = (dec_min == 8'h00) && (dec_sec == 8'h00);
  end

  // Control FSM with registered time, zero and done outputs. zero always mirrors the
  // stored time, so it doubles as the time==00:00 qualifier for start.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= StIdle;
      min_bcd   <= 8'h00;
      sec_bcd   <= 8'h00;
      zero      <= 1'b1;
      done      <= 1'b0;
      prescaler <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (load_rise) begin
            min_bcd <= cap_min;
            sec_bcd <= cap_sec;
            zero    <= cap_zero;
          end else if (start && !zero) begin
            state     <= StRunning;
            prescaler <= '0;
          end
        end
        StRunning: begin
          if (pause) begin
            state <= StPaused;
          end else if (prescaler == PreLast) begin
            prescaler <= '0;
            min_bcd   <= dec_min;
            sec_bcd   <= dec_sec;
            zero      <= dec_zero;
            if (dec_zero) begin
              state <= StDone;
              done  <= 1'b1;
            end
          end else begin
            prescaler <= prescaler + PreOne;
          end
        end
        StPaused: begin
          if (load_rise) begin
            min_bcd <= cap_min;
            sec_bcd <= cap_sec;
            zero    <= cap_zero;
            state   <= StIdle;
          end else if (start && !pause && !zero) begin
            state     <= StRunning;
            prescaler <= '0;
          end
        end
        StDone: begin
          if (load_rise) begin
            min_bcd <= cap_min;
            sec_bcd <= cap_sec;
            zero    <= cap_zero;
            state   <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign running = (state == StRunning);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random stimulus,
// all compared against a seconds-count reference model.
module tb_countdown_timer;

  localparam int unsigned N = 4;

  logic       clock;
  logic       clear_n;
  logic       load;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic       start;
  logic       pause;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       zero;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  countdown_timer #(.CLK_PER_SEC(N)) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .load       (load),
    .preset_min (preset_min),
    .preset_sec (preset_sec),
    .start      (start),
    .pause      (pause),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .running    (running),
    .zero       (zero),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: time held as a plain count of seconds.
  localparam int MIdle = 0, MRun = 1, MPaused = 2, MDone = 3;
  int   m_mode;
  int   m_secs;
  int   m_ticks;
  logic m_done;
  logic m_load_prev;
  logic m_seen_low;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int preset_total(input logic [7:0] pm, input logic [7:0] ps);
    int mt, mo, st, so;
    mt = (pm[7:4] > 4'd9) ? 9 : int'(pm[7:4]);
    mo = (pm[3:0] > 4'd9) ? 9 : int'(pm[3:0]);
    st = (ps[7:4] > 4'd5) ? 5 : int'(ps[7:4]);
    so = (ps[3:0] > 4'd9) ? 9 : int'(ps[3:0]);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  task automatic model_reset();
    m_mode      = MIdle;
    m_secs      = 0;
    m_ticks     = 0;
    m_done      = 1'b0;
    m_load_prev = 1'b0;
    m_seen_low  = 1'b0;
  endtask

  task automatic model_step();
    logic rise;
    rise   = load && !m_load_prev && m_seen_low;
    m_done = 1'b0;
    case (m_mode)
      MIdle: begin
        if (rise) m_secs = preset_total(preset_min, preset_sec);
        else if (start && m_secs != 0) begin m_mode = MRun; m_ticks = 0; end
      end
      MRun: begin
        if (pause) m_mode = MPaused;
        else begin
          m_ticks++;
          if (m_ticks == N) begin
            m_ticks = 0;
            m_secs--;
            if (m_secs == 0) begin m_mode = MDone; m_done = 1'b1; end
          end
        end
      end
      MPaused: begin
        if (rise) begin m_secs = preset_total(preset_min, preset_sec); m_mode = MIdle; end
        else if (start && !pause && m_secs != 0) begin m_mode = MRun; m_ticks = 0; end
      end
      default: begin
        if (rise) begin m_secs = preset_total(preset_min, preset_sec); m_mode = MIdle; end
      end
    endcase
    m_load_prev = load;
    if (!load) m_seen_low = 1'b1;
  endtask

  task automatic compare_all();
    check_val("min_bcd", 32'(min_bcd), 32'(to_bcd(m_secs / 60)));
    check_val("sec_bcd", 32'(sec_bcd), 32'(to_bcd(m_secs % 60)));
    check_val("running", 32'(running), 32'(m_mode == MRun));
    check_val("zero",    32'(zero),    32'(m_secs == 0));
    check_val("done",    32'(done),    32'(m_done));
  endtask

  task automatic cycle(input logic ld, input logic st, input logic pa);
    load  = ld;
    start = st;
    pause = pa;
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear immediately.
  task automatic do_reset(input logic ld);
    #2;
    clear_n = 1'b0;
    load    = ld;
    model_reset();
    #1;
    compare_all();
    @(negedge clock);
    clear_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_n    = 1'b0;
    load       = 1'b0;
    start      = 1'b0;
    pause      = 1'b0;
    preset_min = 8'h00;
    preset_sec = 8'h00;
    model_reset();
    #12;
    // 1: reset values, start at 00:00 ignored
    check_val("rst_min",     32'(min_bcd), 32'h00);
    check_val("rst_sec",     32'(sec_bcd), 32'h00);
    check_val("rst_running", 32'(running), 32'h0);
    check_val("rst_done",    32'(done),    32'h0);
    check_val("rst_zero",    32'(zero),    32'h1);
    @(negedge clock);
    clear_n = 1'b1;
    cycle(1'b0, 1'b1, 1'b0);
    check_val("start_at_zero_running", 32'(running), 32'h0);

    // 2: 01:01 counts to 01:00 then 00:59
    preset_min = 8'h01; preset_sec = 8'h01;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    idle_cycles(3);
    check_val("t2_before_tick_sec", 32'(sec_bcd), 32'h01);
    idle_cycles(1);
    check_val("t2_first_min", 32'(min_bcd), 32'h01);
    check_val("t2_first_sec", 32'(sec_bcd), 32'h00);
    idle_cycles(4);
    check_val("t2_second_min", 32'(min_bcd), 32'h00);
    check_val("t2_second_sec", 32'(sec_bcd), 32'h59);

    // 3: minute borrow and preset sanitising
    cycle(1'b0, 1'b0, 1'b1);
    preset_min = 8'h10; preset_sec = 8'h00;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    idle_cycles(4);
    check_val("t3_borrow_min", 32'(min_bcd), 32'h09);
    check_val("t3_borrow_sec", 32'(sec_bcd), 32'h59);
    cycle(1'b0, 1'b0, 1'b1);
    preset_min = 8'h9F; preset_sec = 8'h7A;
    cycle(1'b1, 1'b0, 1'b0);
    check_val("t3_sanitise_min", 32'(min_bcd), 32'h99);
    check_val("t3_sanitise_sec", 32'(sec_bcd), 32'h59);
    cycle(1'b0, 1'b0, 1'b0);

    // 4: expiry
    preset_min = 8'h00; preset_sec = 8'h02;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    idle_cycles(8);
    check_val("t4_sec",     32'(sec_bcd), 32'h00);
    check_val("t4_done",    32'(done),    32'h1);
    check_val("t4_running", 32'(running), 32'h0);
    check_val("t4_zero",    32'(zero),    32'h1);
    cycle(1'b0, 1'b0, 1'b0);
    check_val("t4_done_cleared", 32'(done), 32'h0);
    cycle(1'b0, 1'b1, 1'b0);
    check_val("t4_start_in_done", 32'(running), 32'h0);

    // 5: pause, load ignored while running, pause beats start
    preset_min = 8'h00; preset_sec = 8'h31;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    idle_cycles(4);
    check_val("t5_at_30", 32'(sec_bcd), 32'h30);
    cycle(1'b0, 1'b0, 1'b1);
    idle_cycles(20);
    check_val("t5_frozen_sec", 32'(sec_bcd), 32'h30);
    check_val("t5_frozen_running", 32'(running), 32'h0);
    preset_sec = 8'h05;
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check_val("t5_load_ignored", 32'(sec_bcd), 32'h30);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    check_val("t5_pause_wins", 32'(running), 32'h0);
    cycle(1'b0, 1'b1, 1'b0);
    idle_cycles(3);
    check_val("t5_resume_hold", 32'(sec_bcd), 32'h30);
    idle_cycles(1);
    check_val("t5_resume_dec", 32'(sec_bcd), 32'h29);

    // 6: async reset mid-run, load held high across release
    cycle(1'b0, 1'b0, 1'b1);
    preset_min = 8'h05; preset_sec = 8'h17;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    idle_cycles(2);
    check_val("t6_pre_reset_min", 32'(min_bcd), 32'h05);
    do_reset(1'b1);
    check_val("t6_async_min",     32'(min_bcd), 32'h00);
    check_val("t6_async_sec",     32'(sec_bcd), 32'h00);
    check_val("t6_async_running", 32'(running), 32'h0);
    check_val("t6_async_zero",    32'(zero),    32'h1);
    preset_min = 8'h03; preset_sec = 8'h00;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    check_val("t6_no_reload", 32'(min_bcd), 32'h00);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check_val("t6_reload_min", 32'(min_bcd), 32'h03);
    check_val("t6_reload_sec", 32'(sec_bcd), 32'h00);

    // Random stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 9) == 0) begin
          preset_min = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
          preset_sec = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
        end
        cycle(($urandom_range(0, 7) == 0) ? ~load : load,
              1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 15) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
